// File: rtl/dec_scan_pkg.sv
// dec_scan shared constants: mode select values and FSM state codes.
package dec_scan_pkg;

  typedef logic [1:0] state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam state_t S_OFF    = 2'd0;
  localparam state_t S_DIRECT = 2'd1;
  localparam state_t S_SCAN   = 2'd2;

endpackage

// File: rtl/dec_scan_onehot.sv
// Index to one-hot with an enable gate; all-zero when disabled.
module dec_onehot #(
  parameter int IN_W = 3
) (
  input  logic                 en,
  input  logic [IN_W-1:0]      idx,
  output logic [(2**IN_W)-1:0] onehot
);

  localparam int OUT_W = 2**IN_W;

  assign onehot = {{(OUT_W-1){1'b0}}, en} << idx;

endmodule

// File: rtl/dec_scan.sv
// Registered N-to-2^N decoder with a self-running channel scan mode
// for multiplexed display digit/row selects.
module dec_scan
  import dec_scan_pkg::*;
#(
  parameter int IN_W    = 3,
  parameter int DWELL_W = 16,
  parameter int BLANK   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [IN_W-1:0]      in,
  input  logic [IN_W:0]        num_ch,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(2**IN_W)-1:0] out,
  output logic [IN_W-1:0]      sel,
  output logic                 wrap
);

  localparam int OUT_W = 2**IN_W;
  localparam logic [IN_W:0] OUT_N = (IN_W+1)'(OUT_W);
  localparam logic [DWELL_W:0] BLANK_N = (DWELL_W+1)'(BLANK);

  state_t              state;
  state_t              nstate;
  logic                resume;
  logic                resume_next;
  logic [DWELL_W-1:0]  cnt;
  logic [DWELL_W-1:0]  cnt_next;
  logic [IN_W-1:0]     sel_next;
  logic [IN_W:0]       eff_ch;
  logic [IN_W:0]       last;
  logic                wrap_next;
  logic                gate;
  logic [OUT_W-1:0]    out_next;

  // resume marks that the last active state was scan, so an
  // en drop freezes the position instead of restarting it
  always_comb begin
    nstate = !en ? S_OFF :
             (mode == MODE_SCAN) ? S_SCAN : S_DIRECT;
    eff_ch = (num_ch == '0 || num_ch > OUT_N) ?
             OUT_N : num_ch;
    last        = eff_ch - 1'b1;
    sel_next    = sel;
    cnt_next    = cnt;
    wrap_next   = 1'b0;
    gate        = 1'b0;
    resume_next = resume;
    unique case (1'b1)
      (nstate == S_DIRECT): begin
        sel_next    = in;
        cnt_next    = '0;
        gate        = 1'b1;
        resume_next = 1'b0;
      end
      (nstate == S_SCAN): begin
        resume_next = 1'b1;
        if (state == S_DIRECT || (state == S_OFF && !resume)) begin
          sel_next = '0;
          cnt_next = '0;
        end else if (cnt >= dwell) begin
          cnt_next = '0;
          if ({1'b0, sel} >= last) begin
            sel_next  = '0;
            wrap_next = 1'b1;
          end else begin
            sel_next = sel + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
        gate = {1'b0, cnt_next} >= BLANK_N;
      end
      default: ;
    endcase
  end

  dec_onehot #(.IN_W(IN_W)) u_onehot (
    .en     (gate),
    .idx    (sel_next),
    .onehot (out_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_OFF;
      resume <= 1'b0;
      cnt    <= '0;
      sel    <= '0;
      out    <= '0;
      wrap   <= 1'b0;
    end else begin
      state  <= nstate;
      resume <= resume_next;
      cnt    <= cnt_next;
      sel    <= sel_next;
      out    <= out_next;
      wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan: spec-level model checked every cycle on two
// instances (BLANK=0 and BLANK=1), plus directed literal checks.
module tb_dec_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [2:0]  din;
  logic [3:0]  num_ch;
  logic [15:0] dwell;
  logic [7:0]  out0, out1;
  logic [2:0]  sel0, sel1;
  logic        wrap0, wrap1;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  int m_sel = 0;
  int m_cnt = 0;
  bit m_res = 1'b0;
  int ec;
  int e_out0 = 0;
  int e_out1 = 0;
  int e_sel = 0;
  int e_wrap = 0;

  always #5 clk = ~clk;

  dec_scan #(.IN_W(3), .DWELL_W(16), .BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(din),
    .num_ch(num_ch), .dwell(dwell),
    .out(out0), .sel(sel0), .wrap(wrap0)
  );

  dec_scan #(.IN_W(3), .DWELL_W(16), .BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(din),
    .num_ch(num_ch), .dwell(dwell),
    .out(out1), .sel(sel1), .wrap(wrap1)
  );

  task automatic chk(string name, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: sel/cnt are the scan position; m_res says it is resumable
  always @(posedge clk) begin
    ec = (num_ch == 0 || num_ch > 8) ? 8 : int'(num_ch);
    e_wrap = 0;
    if (rst) begin
      m_sel = 0; m_cnt = 0; m_res = 1'b0;
      e_out0 = 0; e_out1 = 0;
    end else if (!en) begin
      e_out0 = 0; e_out1 = 0;
    end else if (!mode) begin
      m_sel = int'(din); m_res = 1'b0;
      e_out0 = 1 << m_sel; e_out1 = 1 << m_sel;
    end else begin
      if (!m_res) begin
        m_sel = 0; m_cnt = 0;
      end else if (m_cnt >= int'(dwell)) begin
        m_cnt = 0;
        if (m_sel >= ec - 1) begin
          m_sel = 0; e_wrap = 1;
        end else begin
          m_sel = m_sel + 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_res = 1'b1;
      e_out0 = 1 << m_sel;
      e_out1 = (m_cnt >= 1) ? (1 << m_sel) : 0;
    end
    e_sel = m_sel;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_out0", int'(out0), e_out0);
      chk("m_sel0", int'(sel0), e_sel);
      chk("m_wrap0", int'(wrap0), e_wrap);
      chk("m_out1", int'(out1), e_out1);
      chk("m_sel1", int'(sel1), e_sel);
      chk("m_wrap1", int'(wrap1), e_wrap);
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] dir_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                              8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] s4_exp [6] = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
  logic       w4_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] b6_exp [9] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00,
                             8'h02, 8'h02, 8'h02, 8'h00};

  initial begin
    int wraps;
    rst = 1'b1; en = 1'b1; mode = 1'b1; din = 3'd5;
    num_ch = 4'd0; dwell = 16'd0;
    chk_on = 1'b1;
    step(2);
    chk("rst_out", int'(out0), 8'h00);
    chk("rst_sel", int'(sel0), 0);
    chk("rst_wrap", int'(wrap0), 0);
    rst = 1'b0; en = 1'b0;
    step(1);
    chk("off_out", int'(out0), 8'h00);

    // direct decode
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = 3'(i);
      step(1);
      chk("dir_out", int'(out0), int'(dir_exp[i]));
      chk("dir_sel", int'(sel0), i);
    end
    en = 1'b0;
    step(1);
    chk("dir_off", int'(out0), 8'h00);

    // full scan, dwell=2
    en = 1'b1; mode = 1'b1; num_ch = 4'd0; dwell = 16'd2;
    wraps = 0;
    for (int c = 1; c <= 48; c++) begin
      step(1);
      wraps += int'(wrap0);
      if (c == 1) chk("s3_c1", int'(out0), 8'h01);
      if (c == 3) chk("s3_c3", int'(out0), 8'h01);
      if (c == 4) chk("s3_c4", int'(out0), 8'h02);
      if (c == 24) chk("s3_c24", int'(out0), 8'h80);
      if (c == 25) chk("s3_c25", int'(out0), 8'h01);
      if (c == 25) chk("s3_w25", int'(wrap0), 1);
    end
    chk("s3_wraps", wraps, 1);

    // 3 channels, dwell=0, then shrink to 2 at sel=2
    mode = 1'b0; step(1);
    mode = 1'b1; num_ch = 4'd3; dwell = 16'd0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      chk("s4_out", int'(out0), int'(s4_exp[c]));
      chk("s4_wrap", int'(wrap0), int'(w4_exp[c]));
    end
    num_ch = 4'd2;
    step(1);
    chk("s4_shr_sel", int'(sel0), 0);
    chk("s4_shr_wrap", int'(wrap0), 1);
    step(1);
    chk("s4_n2_out", int'(out0), 8'h02);
    step(1);
    chk("s4_n2_wrap", int'(wrap0), 1);

    // freeze/resume, dwell=4
    mode = 1'b0; step(1);
    mode = 1'b1; num_ch = 4'd0; dwell = 16'd4;
    step(28);
    chk("s5_sel", int'(sel0), 5);
    chk("s5_out", int'(out0), 8'h20);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("s5_frz_out", int'(out0), 8'h00);
      chk("s5_frz_sel", int'(sel0), 5);
    end
    en = 1'b1;
    step(1); chk("s5_r1", int'(out0), 8'h20);
    step(1); chk("s5_r2", int'(out0), 8'h20);
    step(1); chk("s5_r3", int'(out0), 8'h40);

    // blanking instance, dwell=3, reset mid-slot
    mode = 1'b0; step(1);
    mode = 1'b1; num_ch = 4'd0; dwell = 16'd3;
    for (int c = 0; c < 9; c++) begin
      step(1);
      chk("s6_out1", int'(out1), int'(b6_exp[c]));
    end
    step(2);
    rst = 1'b1;
    step(1);
    chk("s6_rst_out1", int'(out1), 8'h00);
    chk("s6_rst_sel1", int'(sel1), 0);
    rst = 1'b0;

    // single channel, dwell=1
    mode = 1'b0; step(1);
    mode = 1'b1; num_ch = 4'd1; dwell = 16'd1;
    step(2); chk("n1_w2", int'(wrap0), 0);
    step(1); chk("n1_w3", int'(wrap0), 1);
    chk("n1_sel", int'(sel0), 0);
    step(2); chk("n1_w5", int'(wrap0), 1);

    // num_ch above 8 means 8; dwell=0 keeps BLANK=1 dark
    mode = 1'b0; step(1);
    mode = 1'b1; num_ch = 4'd9; dwell = 16'd0;
    step(8); chk("n9_c8", int'(out0), 8'h80);
    step(1); chk("n9_c9", int'(out0), 8'h01);
    chk("n9_w9", int'(wrap0), 1);
    chk("d0_blank", int'(out1), 8'h00);
    step(3);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec_scan.md
Name: dec_scan

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable. It generalises the 3-to-8 decoder family to any input width. It adds a self-running scan mode that walks a programmable number of channels with a programmable dwell and optional blanking. It drives digit/row selects of multiplexed LED/7-segment displays, and also serves as a plain registered decoder in direct mode.

Parameters:
IN_W, 3, select width; output width OUT_W = 2**IN_W (localparam, not overridable)
DWELL_W, 16, width of dwell count
BLANK, 0, leading cycles of each scan slot with out forced to 0 (anti-ghosting)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  enable; 0 forces out=0 and freezes the scan position
mode  in  1  0 = direct decode, 1 = scan
in  in  IN_W  channel select in direct mode
num_ch  in  IN_W+1  scanned channel count; 0 or >OUT_W means OUT_W
dwell  in  DWELL_W  slot length minus 1 (slot = dwell+1 cycles)
out  out  OUT_W  registered one-hot output (or all-zero)
sel  out  IN_W  registered index of the current channel
wrap  out  1  one-cycle pulse when scan returns to channel 0

Behaviour:
- Reset: synchronous and active-high; the clock port is named clk and the reset port rst. On the edge with rst=1: out=0, sel=0, wrap=0, cnt=0, state=S_OFF. Reset asserted mid-scan zeroes all outputs on the next edge.
- States: S_OFF (en=0), S_DIRECT (en=1, mode=0), S_SCAN (en=1, mode=1). The state is re-evaluated every edge from en and mode.
- S_DIRECT:
  - out <= 1<<in; sel <= in; wrap <= 0.
  - Latency is exactly 1 cycle. There is no glitch between codes, because out is a register.
- S_OFF:
  - out <= 0; wrap <= 0.
  - sel and cnt hold their values, so the scan position is frozen.
- Entering S_SCAN from S_DIRECT, or from reset: sel <= 0, cnt <= 0.
- Entering S_SCAN from S_OFF when the previous active state was S_SCAN: resume with the held sel and cnt, and continue counting.
- S_SCAN, each edge:
  - If cnt >= dwell: cnt <= 0 and sel <= (sel == last) ? 0 : sel+1, where last = eff_ch-1.
  - Otherwise: cnt <= cnt+1 and sel holds.
  - wrap <= 1 exactly on the edge where sel goes from last to 0; otherwise 0.
- Output in S_SCAN: out <= (cnt_next >= BLANK) ? 1<<sel_next : 0, so out, sel and wrap stay cycle-aligned.
- eff_ch = (num_ch == 0 || num_ch > OUT_W) ? OUT_W : num_ch.
- eff_ch = 1: sel stays 0; wrap pulses every dwell+1 cycles.
- num_ch reduced below the current sel+1: on the next slot boundary, sel >= last, so it wraps to 0 and wrap pulses.
- dwell changed mid-slot: the new value is compared immediately. If cnt already exceeds it, the slot ends on the next edge.
- dwell=0: advance every cycle. If BLANK >= 1, out stays 0 permanently. This is legal and documented.
- BLANK >= dwell+1: out stays all-zero while sel and wrap still sequence.
- Widths: all counters are unsigned. cnt is DWELL_W bits and never exceeds max(dwell, previous dwell).

Decomposition:
- Package/header dec_scan_pkg:
  - mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1
  - state encodings S_OFF, S_DIRECT, S_SCAN (2-bit)
- Sub-module dec_onehot (combinational, parameter IN_W): maps an index to a one-hot value with an enable gate. It is instantiated once, on the sel_next path.
- The FSM, dwell counter and index counter live in dec_scan.

Test Plan:
1. rst=1 for 2 cycles with any inputs -> out=8'h00, sel=0, wrap=0. Release with en=0 -> out stays 8'h00.
2. Direct mode, en=1, in=0..7 one per cycle -> out = 01,02,04,08,10,20,40,80, each exactly 1 cycle after in. Then en=0 -> out=00 the next cycle.
3. Scan mode, num_ch=0, dwell=2 -> out holds 01 for 3 cycles, then 02 … 80. wrap pulses once every 24 cycles, on the cycle out returns to 01.
4. Scan mode, num_ch=3, dwell=0 -> out sequence 01,02,04,01,… with a wrap pulse every 3rd cycle. Change num_ch to 2 while sel=2 -> next edge sel=0 with a wrap pulse.
5. Scan mode, dwell=4: drop en for 5 cycles while sel=5, cnt=2 -> out=00 and sel=5 held. Restore en -> out=20 for the remaining 2 cycles, then 40.
6. BLANK=1 instance, dwell=3 -> each slot is 00 then 3×one-hot (00,01,01,01,00,02,…). Assert rst mid-slot -> out=00, sel=0 on the next edge.
